fft_stage_sequencer: RTL and testbench

- Sequences an in-place radix-2 DIT FFT of N = 2**LOG2_NFFT points.
- For every stage, issues one butterfly command per handshake. Each command carries the two operand memory addresses and the twiddle ROM address.
- Inserts a pipeline-drain gap between stages to avoid read-after-write hazards.
- Sits between the top-level control (start/done) and the butterfly datapath plus twiddle ROM (2**(LOG2_NFFT-1) entries).

---
 rtl/fft_stage_sequencer.sv | 165 ++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Purpose : sequences an in-place radix-2 DIT FFT of 2**LOG2_NFFT points, one
//           butterfly command (addr_a, addr_b, tw_addr) per bf_valid/bf_ready
//           handshake, with PIPE_LAT idle cycles between stages.
// Latency : first command valid the cycle after start is accepted; done pulses
//           PIPE_LAT cycles after the last handshake of the final stage.
// Backpressure: bf_ready=0 stalls the sequencer and holds every output stable.
// Ports   : clk, rst_n (async active-low), start, abort, bf_ready in;
//           bf_valid, addr_a, addr_b, tw_addr, stage, busy, done out.
// Option  : FFT_IFFT_EN adds input inverse and output tw_conj (inverse latched
//           at start, held until return to IDLE).
module fft_stage_sequencer #(
  parameter int LOG2_NFFT = 5,
  parameter int PIPE_LAT  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         bf_ready,
`ifdef FFT_IFFT_EN
  input  logic                         inverse,
  output logic                         tw_conj,
`endif
  output logic                         bf_valid,
  output logic [LOG2_NFFT-1:0]         addr_a,
  output logic [LOG2_NFFT-1:0]         addr_b,
  output logic [LOG2_NFFT-1:0]         tw_addr,
  output logic [$clog2(LOG2_NFFT)-1:0] stage,
  output logic                         busy,
  output logic                         done
);

  localparam int SW = $clog2(LOG2_NFFT);
  localparam int KW = LOG2_NFFT - 1;
  localparam int WW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [KW-1:0] K_LAST  = '1;
  localparam logic [SW-1:0] S_LAST  = SW'(LOG2_NFFT - 1);
  localparam logic [WW-1:0] W_LAST  = WW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
  localparam logic [SW:0]   TW_TOP  = (SW+1)'(LOG2_NFFT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT, ST_DONE} state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [WW-1:0] wcnt;
  logic          last_stage;

  // Address decode from (stage, k). Shift amounts are one bit wider than
  // stage because stage+1 can reach LOG2_NFFT.
  logic [LOG2_NFFT-1:0] k_w, half, p, j, a_dec;
  logic [SW:0]          s_p1, tw_sh;

  always_comb begin
    k_w   = {1'b0, k};
    half  = LOG2_NFFT'(1) << stage;
    p     = k_w & (half - LOG2_NFFT'(1));
    j     = k_w >> stage;
    s_p1  = {1'b0, stage} + (SW+1)'(1);
    tw_sh = TW_TOP - {1'b0, stage};
    a_dec = (j << s_p1) | p;
  end

  // Addresses are forced to zero outside a transform so that reset and IDLE
  // present all-zero outputs (stage=0,k=0 would otherwise decode addr_b=1).
  assign addr_a  = busy ? a_dec          : '0;
  assign addr_b  = busy ? (a_dec + half) : '0;
  assign tw_addr = busy ? (p << tw_sh)   : '0;

  assign last_stage = (stage == S_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      stage    <= '0;
      k        <= '0;
      wcnt     <= '0;
      bf_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef FFT_IFFT_EN
      tw_conj  <= 1'b0;
`endif
    end else if (abort) begin
      // Abort wins over handshake and start; in IDLE this is a no-op clear.
      state    <= ST_IDLE;
      stage    <= '0;
      k        <= '0;
      wcnt     <= '0;
      bf_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef FFT_IFFT_EN
      tw_conj  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_RUN;
            stage    <= '0;
            k        <= '0;
            bf_valid <= 1'b1;
            busy     <= 1'b1;
`ifdef FFT_IFFT_EN
            tw_conj  <= inverse;
`endif
          end
        end

        ST_RUN: begin
          if (bf_ready) begin
            if (k == K_LAST) begin
              k <= '0;
              if (PIPE_LAT == 0) begin
                // No drain gap: apply the stage-exit decision immediately.
                if (last_stage) begin
                  state    <= ST_DONE;
                  bf_valid <= 1'b0;
                  done     <= 1'b1;
                end else begin
                  stage <= stage + SW'(1);
                end
              end else begin
                state    <= ST_WAIT;
                bf_valid <= 1'b0;
                wcnt     <= '0;
              end
            end else begin
              k <= k + KW'(1);
            end
          end
        end

        ST_WAIT: begin
          if (wcnt == W_LAST) begin
            if (last_stage) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_RUN;
              stage    <= stage + SW'(1);
              bf_valid <= 1'b1;
            end
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          stage <= '0;
          done  <= 1'b0;
          busy  <= 1'b0;
`ifdef FFT_IFFT_EN
          tw_conj <= 1'b0;
`endif
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Purpose : directed bench for fft_stage_sequencer (LOG2_NFFT=3), PIPE_LAT=3
//           main instance plus a PIPE_LAT=0 instance sharing rst_n/start.
// Latency : n/a (bench); each run records outputs for a fixed cycle window.
// Backpressure: bf_ready driven per cycle from the run parameters.
module tb_fft_stage_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort, bf_ready;
  logic       bf_valid, busy, done;
  logic [2:0] addr_a, addr_b, tw_addr;
  logic [1:0] stage;

  logic       abort_z, bf_ready_z;
  logic       bf_valid_z, busy_z, done_z;
  logic [2:0] addr_a_z, addr_b_z, tw_addr_z;
  logic [1:0] stage_z;

`ifdef FFT_IFFT_EN
  logic inverse, tw_conj, tw_conj_z;
`endif

  fft_stage_sequencer #(.LOG2_NFFT(3), .PIPE_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bf_ready(bf_ready),
`ifdef FFT_IFFT_EN
    .inverse(inverse), .tw_conj(tw_conj),
`endif
    .bf_valid(bf_valid), .addr_a(addr_a), .addr_b(addr_b), .tw_addr(tw_addr),
    .stage(stage), .busy(busy), .done(done)
  );

  fft_stage_sequencer #(.LOG2_NFFT(3), .PIPE_LAT(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort_z), .bf_ready(bf_ready_z),
`ifdef FFT_IFFT_EN
    .inverse(1'b0), .tw_conj(tw_conj_z),
`endif
    .bf_valid(bf_valid_z), .addr_a(addr_a_z), .addr_b(addr_b_z), .tw_addr(tw_addr_z),
    .stage(stage_z), .busy(busy_z), .done(done_z)
  );

  int checks = 0;
  int errors = 0;

  // Per-cycle record of the last run, indexed by cycle number (cycle 1 is the
  // first cycle after the start edge).
  bit rec_v[64], rec_done[64], rec_busy[64], rec_hs[64], rec_conj[64];
  bit rec_vz[64], rec_dz[64];
  int rec_cmd[64], rec_stage[64];

  // Expected handshake order for N=8.
  int exp_a[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int pack_cmd(input int a, input int b, input int tw);
    return a * 64 + b * 8 + tw;
  endfunction

  function automatic int vec(input bit arr[64]);
    int v = 0;
    for (int i = 1; i < 31; i++) if (arr[i]) v |= (1 << i);
    return v;
  endfunction

  function automatic int rng(input int lo, input int hi);
    int v = 0;
    for (int i = lo; i <= hi; i++) v |= (1 << i);
    return v;
  endfunction

  function automatic int hs_count();
    int n = 0;
    for (int i = 1; i < 64; i++) if (rec_hs[i]) n++;
    return n;
  endfunction

  // One transform: start, then ncyc recorded cycles. bf_ready is low in
  // cycles rlo..rhi, abort is high in cycle ab_cyc, start is re-pulsed in
  // cycle st2_cyc.
  task automatic run(input int ncyc, input int rlo, input int rhi,
                     input int ab_cyc, input int st2_cyc, input bit inv);
    for (int i = 0; i < 64; i++) begin
      rec_v[i] = 0; rec_done[i] = 0; rec_busy[i] = 0; rec_hs[i] = 0;
      rec_conj[i] = 0; rec_vz[i] = 0; rec_dz[i] = 0; rec_cmd[i] = -1; rec_stage[i] = -1;
    end
    @(posedge clk); #1;
    start = 1'b1;
`ifdef FFT_IFFT_EN
    inverse = inv;
`endif
    @(posedge clk); #1;
    start = 1'b0;
`ifdef FFT_IFFT_EN
    inverse = 1'b0;
`endif
    for (int c = 1; c <= ncyc; c++) begin
      bf_ready = !(c >= rlo && c <= rhi);
      abort    = (c == ab_cyc);
      start    = (c == st2_cyc);
      @(negedge clk);
      rec_v[c]     = bf_valid;
      rec_done[c]  = done;
      rec_busy[c]  = busy;
      rec_hs[c]    = bf_valid && bf_ready;
      rec_cmd[c]   = pack_cmd(int'(addr_a), int'(addr_b), int'(tw_addr));
      rec_stage[c] = int'(stage);
      rec_vz[c]    = bf_valid_z;
      rec_dz[c]    = done_z;
`ifdef FFT_IFFT_EN
      rec_conj[c]  = tw_conj;
`endif
      @(posedge clk); #1;
    end
    abort = 1'b0; start = 1'b0; bf_ready = 1'b1;
  endtask

  task automatic check_cmds(input string tag);
    int idx = 0;
    for (int c = 1; c < 64; c++) begin
      if (rec_hs[c]) begin
        if (idx < 12)
          check($sformatf("%s_cmd%0d", tag, idx), rec_cmd[c],
                pack_cmd(exp_a[idx], exp_b[idx], exp_tw[idx]));
        idx++;
      end
    end
    check($sformatf("%s_ncmd", tag), idx, 12);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bf_ready = 1'b1;
    abort_z = 1'b0; bf_ready_z = 1'b1;
`ifdef FFT_IFFT_EN
    inverse = 1'b0;
`endif
    #12;
    check("rst_valid", int'(bf_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", pack_cmd(int'(addr_a), int'(addr_b), int'(tw_addr)), 0);
    check("rst_stage", int'(stage), 0);
    @(negedge clk); rst_n = 1'b1;

    // Full transform with bf_ready=1: order, timing, PIPE_LAT=0 timing.
    run(24, 100, 0, 0, 0, 1'b0);
    check_cmds("full");
    check("full_valid", vec(rec_v), rng(1, 4) | rng(8, 11) | rng(15, 18));
    check("full_done", vec(rec_done), 1 << 22);
    check("full_busy", vec(rec_busy), rng(1, 22));
    check("full_stage8", rec_stage[8], 1);
    check("full_stage15", rec_stage[15], 2);
    check("z_valid", vec(rec_vz), rng(1, 12));
    check("z_done", vec(rec_dz), 1 << 13);

    // Backpressure in cycles 2-4 of stage 0.
    run(27, 2, 4, 0, 0, 1'b0);
    check_cmds("bp");
    for (int c = 2; c <= 5; c++)
      check($sformatf("bp_hold%0d", c), rec_cmd[c], pack_cmd(2, 3, 0));
    check("bp_done", vec(rec_done), 1 << 25);

    // Abort in cycle 9 (stage 1, k=1).
    run(14, 100, 0, 9, 0, 1'b0);
    check("ab_stage9", rec_stage[9], 1);
    check("ab_cmd9", rec_cmd[9], pack_cmd(1, 3, 2));
    check("ab_busy10", int'(rec_busy[10]), 0);
    check("ab_valid10", int'(rec_valid_at(10)), 0);
    check("ab_nodone", vec(rec_done), 0);
    check("ab_nhs", hs_count(), 6);

    // start together with abort in IDLE: stays IDLE.
    @(posedge clk); #1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("sa_busy", int'(busy), 0);
    check("sa_valid", int'(bf_valid), 0);

    // Replay after abort starts again from stage 0.
    run(24, 100, 0, 0, 0, 1'b0);
    check_cmds("replay");
    check("replay_done", vec(rec_done), 1 << 22);

    // start re-pulsed while busy is ignored.
    run(24, 100, 0, 0, 5, 1'b0);
    check("rs_done", vec(rec_done), 1 << 22);
    check("rs_busy", vec(rec_busy), rng(1, 22));
    check("rs_nhs", hs_count(), 12);

`ifdef FFT_IFFT_EN
    run(24, 100, 0, 0, 0, 1'b1);
    check("conj_vec", vec(rec_conj), rng(1, 22));
`endif

    // Asynchronous reset mid-transform.
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(bf_valid), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_addr", pack_cmd(int'(addr_a), int'(addr_b), int'(tw_addr)), 0);
    check("arst_stage", int'(stage), 0);
`ifdef FFT_IFFT_EN
    check("arst_conj", int'(tw_conj), 0);
`endif
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic bit rec_valid_at(input int c);
    return rec_v[c];
  endfunction

endmodule
